// File: rtl/tape_loader_if.sv
// Symbol/command bundle between a symbol source, the tape loader and the tape.
// sym_valid/sym_ready: a symbol transfers on a rising edge where both are high; the source holds sym_in stable while sym_valid is high.
interface tape_loader_if;
    logic [3:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;
    logic       del_req;
    logic       del_done;
    logic       restart;
    logic [3:0] tape_new_symbol;
    logic       tape_set_symbol;
    logic       tape_move;
    logic       tape_move_dir;
    logic       roll_back;
    logic       tape_delete;
    logic [7:0] count;
    logic       overflow;
    logic       done;
    logic [2:0] fsm_state;

    modport slave (
        input  sym_in, sym_valid, del_req, restart,
        output sym_ready, del_done, tape_new_symbol, tape_set_symbol, tape_move,
        output tape_move_dir, roll_back, tape_delete, count, overflow, done, fsm_state
    );

    modport master (
        output sym_in, sym_valid, del_req, restart,
        input  sym_ready, del_done, tape_new_symbol, tape_set_symbol, tape_move,
        input  tape_move_dir, roll_back, tape_delete, count, overflow, done, fsm_state
    );
endinterface

// File: rtl/tape_loader.sv
// Writes a stream of program symbols onto the Brainfuck tape, handling backspace
// and rewinding the tape pointer to cell 0 when the halt symbol arrives.
module tape_loader #(
    parameter int         TAPE_CELLS = 128,
    parameter logic [3:0] HALT_SYM   = 4'b0000
) (
    input  logic          working_clock,
    input  logic          reset,
    tape_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_ADVANCE,
        S_BACK,
        S_ERASE,
        S_REWIND,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_CELL = 8'(TAPE_CELLS - 1);

    state_t     state;
    logic [7:0] count_q;
    logic       overflow_q;
    logic       done_q;
    logic [3:0] new_symbol_q;
    logic       set_q;
    logic       move_q;
    logic       dir_q;
    logic       roll_q;
    logic       delete_q;
    logic       del_done_q;
    logic       wants_delete;

    // Backspace wins over a pending symbol, so the symbol is held off while it runs.
    assign wants_delete  = bus.del_req && (count_q != 8'd0);
    assign bus.sym_ready = (state == S_IDLE) && !wants_delete;

    always_ff @(posedge working_clock) begin
        if (reset) begin
            state        <= S_INIT;
            count_q      <= 8'd0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            new_symbol_q <= 4'd0;
            set_q        <= 1'b0;
            move_q       <= 1'b0;
            dir_q        <= 1'b0;
            roll_q       <= 1'b0;
            delete_q     <= 1'b0;
            del_done_q   <= 1'b0;
        end else begin
            // Command outputs are one-cycle pulses raised on entry to their state.
            new_symbol_q <= 4'd0;
            set_q        <= 1'b0;
            move_q       <= 1'b0;
            dir_q        <= 1'b0;
            roll_q       <= 1'b0;
            delete_q     <= 1'b0;
            del_done_q   <= 1'b0;

            case (state)
                S_INIT: begin
                    state <= S_IDLE;
                end
                S_IDLE: begin
                    if (wants_delete) begin
                        state  <= S_BACK;
                        move_q <= 1'b1;
                    end else if (bus.sym_valid) begin
                        if (bus.sym_in == HALT_SYM) begin
                            state  <= S_REWIND;
                            roll_q <= 1'b1;
                        end else if (count_q == LAST_CELL) begin
                            overflow_q <= 1'b1;
                        end else begin
                            state        <= S_WRITE;
                            set_q        <= 1'b1;
                            new_symbol_q <= bus.sym_in;
                        end
                    end
                end
                S_WRITE: begin
                    state  <= S_ADVANCE;
                    move_q <= 1'b1;
                    dir_q  <= 1'b1;
                end
                S_ADVANCE: begin
                    if (count_q != LAST_CELL) begin
                        count_q <= count_q + 8'd1;
                    end
                    state <= S_IDLE;
                end
                S_BACK: begin
                    if (count_q != 8'd0) begin
                        count_q <= count_q - 8'd1;
                    end
                    state      <= S_ERASE;
                    delete_q   <= 1'b1;
                    del_done_q <= 1'b1;
                end
                S_ERASE: begin
                    state <= S_IDLE;
                end
                S_REWIND: begin
                    state  <= S_DONE;
                    done_q <= 1'b1;
                end
                S_DONE: begin
                    // Old tape contents stay; count alone marks the new program's end.
                    if (bus.restart) begin
                        state      <= S_IDLE;
                        count_q    <= 8'd0;
                        overflow_q <= 1'b0;
                        done_q     <= 1'b0;
                    end
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

    assign bus.tape_new_symbol = new_symbol_q;
    assign bus.tape_set_symbol = set_q;
    assign bus.tape_move       = move_q;
    assign bus.tape_move_dir   = dir_q;
    assign bus.roll_back       = roll_q;
    assign bus.tape_delete     = delete_q;
    assign bus.del_done        = del_done_q;
    assign bus.count           = count_q;
    assign bus.overflow        = overflow_q;
    assign bus.done            = done_q;
    assign bus.fsm_state       = state;
endmodule

// File: tb/tb_tape_loader.sv
// Self-checking bench for tape_loader: a queue-of-expected-commands model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_tape_loader;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tape_loader_if bus();

    tape_loader dut (
        .working_clock (clk),
        .reset         (rst),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each entry is one expected command cycle {set, sym[3:0], move, dir, roll, del, del_done}.
    logic [9:0] exp_q[$];
    logic       m_valid = 1'b0;
    logic       m_init;
    logic       m_done;
    logic       m_ovf;
    int         m_count;

    function automatic logic [9:0] cmd_set(input logic [3:0] s);
        return {1'b1, s, 5'b00000};
    endfunction

    localparam logic [9:0] CMD_FWD   = 10'b0_0000_11000;
    localparam logic [9:0] CMD_BACK  = 10'b0_0000_10000;
    localparam logic [9:0] CMD_ROLL  = 10'b0_0000_00100;
    localparam logic [9:0] CMD_ERASE = 10'b0_0000_00011;

    always @(negedge clk) begin
        logic [9:0] exp_cmd;
        logic [9:0] act_cmd;
        logic       exp_ready;
        if (m_valid) begin
            exp_cmd   = (exp_q.size() != 0) ? exp_q[0] : 10'd0;
            exp_ready = !m_init && !m_done && (exp_q.size() == 0) && !(bus.del_req && m_count != 0);
            act_cmd   = {bus.tape_set_symbol, bus.tape_new_symbol, bus.tape_move, bus.tape_move_dir,
                         bus.roll_back, bus.tape_delete, bus.del_done};
            check("cmd", 32'(act_cmd), 32'(exp_cmd));
            check("sym_ready", 32'(bus.sym_ready), 32'(exp_ready));
            check("count", 32'(bus.count), 32'(m_count));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
            check("done", 32'(bus.done), 32'(m_done));
        end
        // Predict what the coming rising edge does.
        if (rst) begin
            m_valid = 1'b1;
            m_init  = 1'b1;
            m_done  = 1'b0;
            m_ovf   = 1'b0;
            m_count = 0;
            exp_q.delete();
        end else if (!m_valid) begin
        end else if (m_init) begin
            m_init = 1'b0;
        end else if (exp_q.size() != 0) begin
            exp_cmd = exp_q.pop_front();
            if (exp_cmd == CMD_FWD)  m_count = m_count + 1;
            if (exp_cmd == CMD_BACK) m_count = m_count - 1;
            if (exp_cmd == CMD_ROLL) m_done = 1'b1;
        end else if (m_done) begin
            if (bus.restart) begin
                m_done  = 1'b0;
                m_ovf   = 1'b0;
                m_count = 0;
            end
        end else if (bus.del_req && m_count != 0) begin
            exp_q.push_back(CMD_BACK);
            exp_q.push_back(CMD_ERASE);
        end else if (bus.sym_valid) begin
            if (bus.sym_in == 4'd0) begin
                exp_q.push_back(CMD_ROLL);
            end else if (m_count == 127) begin
                m_ovf = 1'b1;
            end else begin
                exp_q.push_back(cmd_set(bus.sym_in));
                exp_q.push_back(CMD_FWD);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [3:0] s);
        bit ok;
        ok = 1'b0;
        bus.sym_in    = s;
        bus.sym_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.sym_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: sym %0h never accepted", s);
        end
        bus.sym_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.sym_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: sym_ready stayed low");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done never rose");
        end
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        tick(1);
        bus.restart = 1'b0;
    endtask

    task automatic pulse_del();
        bus.del_req = 1'b1;
        tick(1);
        bus.del_req = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.sym_in    = 4'd0;
        bus.sym_valid = 1'b0;
        bus.del_req   = 1'b0;
        bus.restart   = 1'b0;

        // Reset and the single INIT cycle.
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        check("init_ready", 32'(bus.sym_ready), 32'd0);
        check("init_count", 32'(bus.count), 32'd0);
        @(negedge clk);
        check("idle_ready", 32'(bus.sym_ready), 32'd1);
        @(posedge clk);
        #1;

        // Load 1, 2, halt back-to-back.
        send_sym(4'd1);
        send_sym(4'd2);
        send_sym(4'd0);
        wait_done();
        check("load_count", 32'(bus.count), 32'd2);
        check("load_done", 32'(bus.done), 32'd1);
        check("load_ready", 32'(bus.sym_ready), 32'd0);
        pulse_restart();
        @(negedge clk);
        check("restart_count", 32'(bus.count), 32'd0);
        @(posedge clk);
        #1;

        // Backspace, then backspace at an empty tape.
        send_sym(4'd5);
        send_sym(4'd6);
        wait_idle();
        pulse_del();
        wait_idle();
        check("bs_count", 32'(bus.count), 32'd1);
        pulse_del();
        wait_idle();
        bus.del_req = 1'b1;
        tick(3);
        bus.del_req = 1'b0;
        check("bs_empty_count", 32'(bus.count), 32'd0);

        // Delete and symbol together at count 3.
        send_sym(4'd7);
        send_sym(4'd8);
        send_sym(4'd9);
        wait_idle();
        bus.del_req   = 1'b1;
        bus.sym_in    = 4'd10;
        bus.sym_valid = 1'b1;
        @(negedge clk);
        check("simul_ready", 32'(bus.sym_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.del_req = 1'b0;
        send_sym(4'd10);
        wait_idle();
        check("simul_count", 32'(bus.count), 32'd3);

        // Fill to capacity, overflow, halt, restart.
        for (int i = 0; i < 124; i++) send_sym(4'($urandom_range(1, 11)));
        wait_idle();
        check("full_count", 32'(bus.count), 32'd127);
        send_sym(4'd3);
        tick(2);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd127);
        send_sym(4'd0);
        wait_done();
        check("ovf_done", 32'(bus.done), 32'd1);
        pulse_restart();
        @(negedge clk);
        check("ovf_restart_count", 32'(bus.count), 32'd0);
        check("ovf_restart_flag", 32'(bus.overflow), 32'd0);
        @(posedge clk);
        #1;

        // Random traffic, changing inputs every cycle.
        for (int i = 0; i < 3000; i++) begin
            bus.sym_valid = ($urandom_range(0, 1) == 1);
            bus.sym_in    = ($urandom_range(0, 15) == 0) ? 4'd0 : 4'($urandom_range(1, 11));
            bus.del_req   = ($urandom_range(0, 9) == 0);
            bus.restart   = ($urandom_range(0, 19) == 0);
            tick(1);
        end
        bus.sym_valid = 1'b0;
        bus.del_req   = 1'b0;
        bus.restart   = 1'b0;
        tick(4);
        if (bus.done) pulse_restart();

        // Reset in the middle of ADVANCE.
        wait_idle();
        send_sym(4'd4);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_count", 32'(bus.count), 32'd0);
        check("midrst_move", 32'(bus.tape_move), 32'd0);
        check("midrst_ready", 32'(bus.sym_ready), 32'd0);
        @(negedge clk);
        check("midrst_idle", 32'(bus.sym_ready), 32'd1);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
